// File: rtl/correlator_hostctrl.sv
// Host byte-protocol controller: decodes command/data bytes into correlator config
// registers and strobes, and drains the packet FIFO singly or in counted bursts.
// Optional burst empty-FIFO timeout: define CORRELATOR_HOSTCTRL_BURST_TIMEOUT_EN.
module correlator_hostctrl #(
  parameter int unsigned MAX_WINDOW_LENGTH_EXP = 16,
  parameter int unsigned MAX_SAMPLE_PERIOD_EXP = 15,
  parameter int unsigned MAX_SAMPLE_JITTER_EXP = 8,
  parameter logic [7:0]  VERSION               = 8'h01,
  parameter int unsigned BURST_TIMEOUT         = 1024,
  localparam int unsigned W_WL = $clog2(MAX_WINDOW_LENGTH_EXP + 1),
  localparam int unsigned W_SP = $clog2(MAX_SAMPLE_PERIOD_EXP + 1),
  localparam int unsigned W_SJ = $clog2(MAX_SAMPLE_JITTER_EXP + 1)
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_cg,
  input  logic [7:0]      i_rxData,
  input  logic            i_rxValid,
  output logic            o_rxReady,
  output logic [7:0]      o_txData,
  output logic            o_txValid,
  input  logic            i_txReady,
  output logic [W_WL-1:0] o_windowLengthExp,
  output logic            o_windowShape,
  output logic [W_SP-1:0] o_samplePeriodExp,
  output logic [W_SJ-1:0] o_sampleJitterExp,
  output logic [2:0]      o_pwmSelect,
  output logic            o_wr_samplePeriod,
  output logic [7:0]      o_jitterSeedByte,
  output logic            o_jitterSeedValid,
  input  logic [7:0]      i_pktfifo_data,
  input  logic            i_pktfifo_empty,
  output logic            o_pktfifo_pop,
  output logic            o_pktfifo_flush
);

  localparam logic [6:0] A_WL      = 7'd0;
  localparam logic [6:0] A_SHAPE   = 7'd1;
  localparam logic [6:0] A_SP      = 7'd2;
  localparam logic [6:0] A_SJ      = 7'd3;
  localparam logic [6:0] A_PWM     = 7'd4;
  localparam logic [6:0] A_SEED    = 7'd5;
  localparam logic [6:0] A_PKT     = 7'd6;
  localparam logic [6:0] A_FLUSH   = 7'd7;
  localparam logic [6:0] A_BURST   = 7'd8;
  localparam logic [6:0] A_VERSION = 7'h7F;

  typedef enum logic [1:0] {S_IDLE, S_WDATA, S_RRESP, S_BURST} state_e;

  state_e            state_q, state_d;
  logic [6:0]        addr_q, addr_d;
  logic [7:0]        count_q, count_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic [W_WL-1:0]   wl_q, wl_d;
  logic              shape_q, shape_d;
  logic [W_SP-1:0]   sp_q, sp_d;
  logic [W_SJ-1:0]   sj_q, sj_d;
  logic [2:0]        pwm_q, pwm_d;
  logic              wr_sp_q, wr_sp_d;
  logic [7:0]        seed_byte_q, seed_byte_d;
  logic              seed_valid_q, seed_valid_d;
  logic              flush_q, flush_d;

  logic              rx_ready_c, tx_valid_c, rx_hs_c, tx_hs_c, pop_c;
  logic [7:0]        rd_data_c;

`ifdef CORRELATOR_HOSTCTRL_BURST_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(BURST_TIMEOUT + 1);
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
`endif

  assign rx_ready_c = (state_q == S_IDLE) || (state_q == S_WDATA);
  assign tx_valid_c = (state_q == S_RRESP) || ((state_q == S_BURST) && !i_pktfifo_empty);
  // Handshakes are masked during reset so an abandoned burst never pops.
  assign rx_hs_c    = rx_ready_c && i_rxValid && i_cg && !i_rst;
  assign tx_hs_c    = tx_valid_c && i_txReady && i_cg && !i_rst;

  assign o_rxReady         = rx_ready_c;
  assign o_txValid         = tx_valid_c;
  assign o_txData          = (state_q == S_BURST) ? i_pktfifo_data : tx_data_q;
  assign o_pktfifo_pop     = pop_c;
  assign o_windowLengthExp = wl_q;
  assign o_windowShape     = shape_q;
  assign o_samplePeriodExp = sp_q;
  assign o_sampleJitterExp = sj_q;
  assign o_pwmSelect       = pwm_q;
  assign o_jitterSeedByte  = seed_byte_q;
  assign o_wr_samplePeriod = wr_sp_q && i_cg;
  assign o_jitterSeedValid = seed_valid_q && i_cg;
  assign o_pktfifo_flush   = flush_q && i_cg;

  // Read-data mux, addressed by the command byte currently on the rx port.
  always_comb begin
    rd_data_c = 8'h00;
    case (i_rxData[6:0])
      A_WL:      rd_data_c = 8'(wl_q);
      A_SHAPE:   rd_data_c = 8'(shape_q);
      A_SP:      rd_data_c = 8'(sp_q);
      A_SJ:      rd_data_c = 8'(sj_q);
      A_PWM:     rd_data_c = 8'(pwm_q);
      A_PKT:     rd_data_c = i_pktfifo_empty ? 8'h00 : i_pktfifo_data;
      A_VERSION: rd_data_c = VERSION;
      default:   rd_data_c = 8'h00;
    endcase
  end

  // Next-state and command decode.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    count_d      = count_q;
    tx_data_d    = tx_data_q;
    wl_d         = wl_q;
    shape_d      = shape_q;
    sp_d         = sp_q;
    sj_d         = sj_q;
    pwm_d        = pwm_q;
    seed_byte_d  = seed_byte_q;
    wr_sp_d      = 1'b0;
    seed_valid_d = 1'b0;
    flush_d      = 1'b0;
    pop_c        = 1'b0;
`ifdef CORRELATOR_HOSTCTRL_BURST_TIMEOUT_EN
    to_cnt_d     = '0;
`endif
    case (state_q)
      S_IDLE: begin
        if (rx_hs_c) begin
          addr_d = i_rxData[6:0];
          if (i_rxData[7]) begin
            state_d = S_WDATA;
          end else begin
            tx_data_d = rd_data_c;
            pop_c     = (i_rxData[6:0] == A_PKT) && !i_pktfifo_empty;
            state_d   = S_RRESP;
          end
        end
      end
      S_WDATA: begin
        if (rx_hs_c) begin
          state_d = S_IDLE;
          case (addr_q)
            A_WL:    wl_d = (32'(i_rxData) > MAX_WINDOW_LENGTH_EXP) ?
                            W_WL'(MAX_WINDOW_LENGTH_EXP) : W_WL'(i_rxData);
            A_SHAPE: shape_d = i_rxData[0];
            A_SP: begin
              sp_d    = (32'(i_rxData) > MAX_SAMPLE_PERIOD_EXP) ?
                        W_SP'(MAX_SAMPLE_PERIOD_EXP) : W_SP'(i_rxData);
              wr_sp_d = 1'b1;
            end
            A_SJ:    sj_d = (32'(i_rxData) > MAX_SAMPLE_JITTER_EXP) ?
                            W_SJ'(MAX_SAMPLE_JITTER_EXP) : W_SJ'(i_rxData);
            A_PWM:   pwm_d = i_rxData[2:0];
            A_SEED: begin
              seed_byte_d  = i_rxData;
              seed_valid_d = 1'b1;
            end
            A_FLUSH: flush_d = 1'b1;
            A_BURST: begin
              if (i_rxData != 8'h00) begin
                count_d = i_rxData;
                state_d = S_BURST;
              end
            end
            default: ;
          endcase
        end
      end
      S_RRESP: begin
        if (tx_hs_c) state_d = S_IDLE;
      end
      S_BURST: begin
`ifdef CORRELATOR_HOSTCTRL_BURST_TIMEOUT_EN
        to_cnt_d = to_cnt_q;
`endif
        if (tx_hs_c) begin
          pop_c   = 1'b1;
          count_d = count_q - 8'd1;
          if (count_q == 8'd1) state_d = S_IDLE;
`ifdef CORRELATOR_HOSTCTRL_BURST_TIMEOUT_EN
          to_cnt_d = '0;
        end else if (i_pktfifo_empty && i_cg) begin
          if (to_cnt_q == TO_W'(BURST_TIMEOUT - 1)) begin
            to_cnt_d = '0;
            count_d  = 8'd0;
            state_d  = S_IDLE;
          end else begin
            to_cnt_d = to_cnt_q + TO_W'(1);
          end
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and register file; clock gate freezes everything except reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= S_IDLE;
      addr_q       <= 7'd0;
      count_q      <= 8'd0;
      tx_data_q    <= 8'h00;
      wl_q         <= '0;
      shape_q      <= 1'b0;
      sp_q         <= '0;
      sj_q         <= '0;
      pwm_q        <= 3'd0;
      wr_sp_q      <= 1'b0;
      seed_byte_q  <= 8'h00;
      seed_valid_q <= 1'b0;
      flush_q      <= 1'b0;
`ifdef CORRELATOR_HOSTCTRL_BURST_TIMEOUT_EN
      to_cnt_q     <= '0;
`endif
    end else if (i_cg) begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      count_q      <= count_d;
      tx_data_q    <= tx_data_d;
      wl_q         <= wl_d;
      shape_q      <= shape_d;
      sp_q         <= sp_d;
      sj_q         <= sj_d;
      pwm_q        <= pwm_d;
      wr_sp_q      <= wr_sp_d;
      seed_byte_q  <= seed_byte_d;
      seed_valid_q <= seed_valid_d;
      flush_q      <= flush_d;
`ifdef CORRELATOR_HOSTCTRL_BURST_TIMEOUT_EN
      to_cnt_q     <= to_cnt_d;
`endif
    end
  end

endmodule

// File: doc/correlator_hostctrl.md
Name: correlator_hostctrl

Overview:
Byte-stream host controller that configures and drains the correlator core. It decodes a command/data byte protocol from the host link (USB/UART byte FIFO) into correlator configuration registers and strobes. It also sequences pops and flushes of the correlator packet FIFO onto the outgoing byte stream, either singly or as counted bursts. It sits between the host link bytepipes and the correlator instance.

Parameters:
MAX_WINDOW_LENGTH_EXP, 16, upper clamp for window length exponent; output width $clog2(MAX+1)
MAX_SAMPLE_PERIOD_EXP, 15, upper clamp for sample period exponent; output width $clog2(MAX+1)
MAX_SAMPLE_JITTER_EXP, 8, upper clamp for jitter exponent; output width $clog2(MAX+1)
VERSION, 8'h01, constant returned by reads of address 0x7F
BURST_TIMEOUT, 1024, consecutive empty-FIFO cycles before burst abort (optional feature only)

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous reset, active-high
i_cg  in  1  clock gate; all flops advance only when high; all pulses/pops qualified by it
i_rxData  in  8  host command/data byte
i_rxValid  in  1  rx byte valid
o_rxReady  out  1  rx byte accepted when i_rxValid && o_rxReady && i_cg
o_txData  out  8  response byte
o_txValid  out  1  response valid
i_txReady  in  1  response accepted when o_txValid && i_txReady && i_cg
o_windowLengthExp  out  W_WL  config register
o_windowShape  out  1  config register
o_samplePeriodExp  out  W_SP  config register
o_sampleJitterExp  out  W_SJ  config register
o_pwmSelect  out  3  config register
o_wr_samplePeriod  out  1  1-cycle pulse, same cycle the new o_samplePeriodExp is visible
o_jitterSeedByte  out  8  seed byte, valid with o_jitterSeedValid
o_jitterSeedValid  out  1  1-cycle pulse
i_pktfifo_data  in  8  packet FIFO head
i_pktfifo_empty  in  1  packet FIFO empty
o_pktfifo_pop  out  1  pop head (combinational)
o_pktfifo_flush  out  1  1-cycle pulse

Behaviour:
- Command byte: bit7=1 write, 0 read; bits[6:0]=address. A write consumes one following data byte.
- Address map:
  - 0 windowLengthExp RW
  - 1 windowShape RW (data[0])
  - 2 samplePeriodExp RW; write also pulses o_wr_samplePeriod
  - 3 sampleJitterExp RW
  - 4 pwmSelect RW (data[2:0])
  - 5 jitterSeed WO (reads 0)
  - 6 pktfifo RO
  - 7 flush WO
  - 8 burst WO
  - 0x7F VERSION RO
  - Writes to any other address are ignored; reads return 8'h00.
- Exponent writes clamp: value = min(data, MAX_*).
- FSM states:
  - IDLE: o_rxReady=1. A read cmd goes to RRESP; a write cmd goes to WDATA.
  - WDATA: o_rxReady=1. On data handshake, commit the register at the next edge; pulses are registered and appear in cycle c+1. Burst with N=0 goes to IDLE; burst with N>0 loads count and goes to BURST; any other write goes to IDLE.
  - RRESP: o_rxReady=0, o_txValid=1. o_txData is captured at the cmd handshake and held stable until i_txReady, then return to IDLE.
  - BURST: o_rxReady=0, o_txData=i_pktfifo_data, o_txValid=!i_pktfifo_empty, o_pktfifo_pop=o_txValid&&i_txReady&&i_cg. Each pop decrements count; the pop taking count 1 to 0 returns to IDLE.
- Read of address 6:
  - If !i_pktfifo_empty at the cmd handshake: capture head and assert o_pktfifo_pop in that same cycle.
  - If empty: return 8'h00 and do not pop.
- Flush write: data byte ignored; o_pktfifo_flush pulses at c+1.
- Jitter seed write: o_jitterSeedByte=data, o_jitterSeedValid pulses at c+1.
- Read latency: o_txValid rises the cycle after the cmd handshake.
- i_cg low: state, count and registers hold; no pulse or pop is asserted.
- Reset (sync, any state):
  - FSM goes to IDLE; count=0.
  - o_txValid=0, o_rxReady=1, o_txData=0.
  - All config registers 0; pulses 0; o_jitterSeedByte=0.
  - Mid-burst reset abandons the burst without popping.

Optional Feature:
CORRELATOR_HOSTCTRL_BURST_TIMEOUT_EN
- Defined: in BURST, a counter increments on each cycle with i_pktfifo_empty && i_cg and clears on any pop. Reaching BURST_TIMEOUT returns to IDLE with the remaining count discarded.
- Undefined: BURST waits indefinitely for data. The BURST_TIMEOUT parameter is unused and no timeout counter exists.

Test Plan:
- Post-reset read 0x7F, then read 0x00 -> tx bytes 0x01 and 0x00; o_txValid low exactly one cycle between responses.
- Write 0x82,0x0A, then write 0x80,0x20 -> o_samplePeriodExp=10 with o_wr_samplePeriod pulse in the same cycle; o_windowLengthExp clamped to 16; readback returns 0x10.
- Burst write 0x88,0x05 with FIFO holding 3 bytes, i_txReady toggling -> 3 bytes out in order; stall while empty; push 2 more -> total 5 pops, then IDLE and o_rxReady=1.
- Read 0x06 with FIFO empty -> tx 0x00, no pop; with FIFO head 0xA5 -> tx 0xA5, one pop cycle.
- Write 0x85,0x3C then 0x87,0xFF -> o_jitterSeedValid pulse with byte 0x3C; one o_pktfifo_flush pulse; write to 0x10 changes nothing.
- Hold i_txReady=0 in RRESP, assert i_rst -> o_txValid=0 next cycle; i_cg=0 during a burst freezes pops and count.
